// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD display path: FSM encoding and
// the double-dabble adjust constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } bcd_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [6:0] BCD_MAX_2DIGIT = 7'd99;
  localparam logic [3:0] BCD_SAT_DIGIT  = 4'd9;
  localparam logic [2:0] BCD_BIT_COUNT  = 3'd7;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: values 5..9 get +3 so the following left
// shift carries correctly into the next decimal digit.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // Conditional +3; inputs are at most 9, so the sum never leaves the nibble.
  always_comb begin
    adj = nib;
    if (nib >= BCD_ADJ_THRESH) begin
      adj = nib + BCD_ADJ_ADD;
    end else begin
      adj = nib;
    end
  end

endmodule

// File: rtl/bcd_split_2digit.sv
// Sequential 7-bit binary to two-digit BCD converter (one bit per clock)
// with valid/ready handshakes and saturation to 99 on overflow.
module bcd_split_2digit
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          tens,
  output logic [3:0]          ones,
  output logic                overflow
);

  bcd_state_t          state_r;
  logic [2:0]          cnt_r;
  logic [IN_WIDTH-1:0] shreg_r;
  logic [11:0]         acc_r;
  logic [3:0]          tens_r;
  logic [3:0]          ones_r;
  logic                ovf_r;

  logic [11:0]         adj_s;
  logic [11:0]         acc_next_s;
  logic [IN_WIDTH-1:0] shreg_next_s;

  bcd_add3 u_adj_hund (.nib(acc_r[11:8]), .adj(adj_s[11:8]));
  bcd_add3 u_adj_tens (.nib(acc_r[7:4]),  .adj(adj_s[7:4]));
  bcd_add3 u_adj_ones (.nib(acc_r[3:0]),  .adj(adj_s[3:0]));

  // Shift {adjusted accumulator, shift register} left by one bit.
  always_comb begin
    acc_next_s   = {adj_s[10:0], shreg_r[IN_WIDTH-1]};
    shreg_next_s = {shreg_r[IN_WIDTH-2:0], 1'b0};
  end

  // Handshake FSM, bit counter, datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      shreg_r <= '0;
      acc_r   <= 12'd0;
      tens_r  <= 4'd0;
      ones_r  <= 4'd0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            shreg_r <= in_value;
            acc_r   <= 12'd0;
            cnt_r   <= BCD_BIT_COUNT;
            state_r <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc_r   <= acc_next_s;
          shreg_r <= shreg_next_s;
          cnt_r   <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            state_r <= ST_DONE;
            // A non-zero hundreds digit means the value exceeds 99.
            if (acc_next_s[11:8] != 4'd0) begin
              ovf_r  <= 1'b1;
              tens_r <= BCD_SAT_DIGIT;
              ones_r <= BCD_SAT_DIGIT;
            end else begin
              ovf_r  <= 1'b0;
              tens_r <= acc_next_s[7:4];
              ones_r <= acc_next_s[3:0];
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign tens      = tens_r;
  assign ones      = ones_r;
  assign overflow  = ovf_r;

endmodule
